ysyx_22050710_mem_arbiter: RTL and testbench

Round-robin arbiter that lets the instruction fetch unit (IFU) and the load/store unit (LSU) share a single memory port. Only one transaction is outstanding at a time. The block accepts one request, latches its payload, and drives the memory request until the memory grants it. It then routes the memory response back to the requester that owns the transaction. It sits between the IFU/LSU and the memory model or bus bridge in the core.

---
 rtl/ysyx_22050710_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_ysyx_22050710_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU and the LSU.
// One transaction in flight at a time: IDLE picks a requester, REQ drives memory, WAIT routes the response.
module ysyx_22050710_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ifu_req,
  input  logic [ADDR_W-1:0]     i_ifu_addr,
  output logic                  o_ifu_gnt,
  output logic                  o_ifu_rvalid,
  output logic [DATA_W-1:0]     o_ifu_rdata,
  input  logic                  i_lsu_req,
  input  logic                  i_lsu_we,
  input  logic [ADDR_W-1:0]     i_lsu_addr,
  input  logic [DATA_W-1:0]     i_lsu_wdata,
  input  logic [DATA_W/8-1:0]   i_lsu_wmask,
  output logic                  o_lsu_gnt,
  output logic                  o_lsu_rvalid,
  output logic [DATA_W-1:0]     o_lsu_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wmask,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_proto_err,
  output logic [1:0]            o_dbg_state
);

  localparam int MASK_W = DATA_W / 8;

  // Handshakes: requester holds req+payload until its gnt pulse; memory request
  // completes on o_mem_req & i_mem_gnt; each rvalid is a single-cycle pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state;
  logic                owner;
  logic                rr_last;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                proto_err_q;

  logic sel_valid;
  logic sel_lsu;
  logic in_idle;
  logic resp;

  // On a tie the side that did not win last time is chosen.
  assign sel_valid = i_ifu_req | i_lsu_req;
  assign sel_lsu   = i_lsu_req & (~i_ifu_req | ~rr_last);
  assign in_idle   = (state == IDLE) & ~i_rst;
  assign resp      = (state == WAIT) & i_mem_rvalid;

  assign o_ifu_gnt    = in_idle & i_ifu_req & ~sel_lsu;
  assign o_lsu_gnt    = in_idle & sel_lsu;
  assign o_ifu_rvalid = resp & ~owner;
  assign o_lsu_rvalid = resp & owner;
  assign o_ifu_rdata  = i_mem_rdata;
  assign o_lsu_rdata  = i_mem_rdata;

  assign o_mem_req   = (state == REQ);
  assign o_mem_we    = o_mem_req & we_q;
  assign o_mem_addr  = o_mem_req ? addr_q  : '0;
  assign o_mem_wdata = o_mem_req ? wdata_q : '0;
  assign o_mem_wmask = o_mem_req ? wmask_q : '0;

  assign o_proto_err = proto_err_q;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      rr_last     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // A response outside WAIT is dropped but remembered until reset.
      if (i_mem_rvalid && state != WAIT) begin
        proto_err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner   <= sel_lsu;
            rr_last <= sel_lsu;
            we_q    <= sel_lsu & i_lsu_we;
            addr_q  <= sel_lsu ? i_lsu_addr : i_ifu_addr;
            wdata_q <= sel_lsu ? i_lsu_wdata : '0;
            wmask_q <= sel_lsu ? i_lsu_wmask : '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: each task drives one scenario and checks inline.
module tb_ysyx_22050710_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic                clk;
  logic                rst;
  logic                ifu_req;
  logic [ADDR_W-1:0]   ifu_addr;
  logic                ifu_gnt;
  logic                ifu_rvalid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                lsu_req;
  logic                lsu_we;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wmask;
  logic                lsu_gnt;
  logic                lsu_rvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                proto_err;
  logic [1:0]          dbg_state;

  int n_cmp;
  int n_fail;

  ysyx_22050710_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_req(ifu_req), .i_ifu_addr(ifu_addr), .o_ifu_gnt(ifu_gnt),
    .o_ifu_rvalid(ifu_rvalid), .o_ifu_rdata(ifu_rdata),
    .i_lsu_req(lsu_req), .i_lsu_we(lsu_we), .i_lsu_addr(lsu_addr),
    .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask), .o_lsu_gnt(lsu_gnt),
    .o_lsu_rvalid(lsu_rvalid), .o_lsu_rdata(lsu_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_proto_err(proto_err), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ifu_req = 0; ifu_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    ifu_req = 1; lsu_req = 1; mem_rvalid = 1; mem_gnt = 1;
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    sample();
    n_cmp++;
    if ({ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_req, mem_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, mem_req, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wmask} !== '0 || proto_err !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h mask %h perr %b state %0d want all 0", mem_addr, mem_wdata, mem_wmask, proto_err, dbg_state);
    end
    n_cmp++;
    if (ifu_rdata !== 64'h1234_5678_9ABC_DEF0 || lsu_rdata !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h want 123456789abcdef0", ifu_rdata, lsu_rdata);
    end
    tick();
    idle_inputs();
    rst = 0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_req = 1; ifu_addr = 64'h8000_0000;
    sample();
    n_cmp++;
    if (ifu_gnt !== 1'b1 || lsu_gnt !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_read_gnt: ifu_gnt %b lsu_gnt %b mem_req %b want 1 0 0", ifu_gnt, lsu_gnt, mem_req);
    end
    tick();
    ifu_req = 0; ifu_addr = '0; mem_gnt = 1;
    sample();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 1'b0 || dbg_state !== S_REQ) begin
      n_fail++;
      $display("FAIL ifu_read_mem: req %b addr %h we %b state %0d want 1 80000000 0 1", mem_req, mem_addr, mem_we, dbg_state);
    end
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0000_0413;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h413 || lsu_rvalid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_read_resp: rvalid %b rdata %h lsu_rvalid %b mem_req %b want 1 413 0 0", ifu_rvalid, ifu_rdata, lsu_rvalid, mem_req);
    end
    tick();
    mem_rvalid = 0;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL ifu_read_done: rvalid %b state %0d want 0 0", ifu_rvalid, dbg_state);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic exp_lsu;
    do_reset();
    ifu_req = 1; ifu_addr = 64'h1000;
    lsu_req = 1; lsu_we = 0; lsu_addr = 64'h2000;
    for (int t = 0; t < 6; t++) begin
      exp_lsu = (t % 2) == 1;
      sample();
      n_cmp++;
      if (ifu_gnt !== !exp_lsu || lsu_gnt !== exp_lsu) begin
        n_fail++;
        $display("FAIL rr_gnt_%0d: ifu %b lsu %b want %b %b", t, ifu_gnt, lsu_gnt, !exp_lsu, exp_lsu);
      end
      tick();
      mem_gnt = 1;
      sample();
      n_cmp++;
      if (mem_addr !== (exp_lsu ? 64'h2000 : 64'h1000) || ifu_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_addr_%0d: addr %h gnts %b%b want %h 00", t, mem_addr, ifu_gnt, lsu_gnt, exp_lsu ? 64'h2000 : 64'h1000);
      end
      tick();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'(t + 100);
      sample();
      n_cmp++;
      if (ifu_rvalid !== !exp_lsu || lsu_rvalid !== exp_lsu || ifu_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_resp_%0d: rvalid ifu %b lsu %b gnts %b%b want %b %b 00", t, ifu_rvalid, lsu_rvalid, ifu_gnt, lsu_gnt, !exp_lsu, exp_lsu);
      end
      tick();
      mem_rvalid = 0;
    end
    idle_inputs();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_proto: got %b want 0", proto_err);
    end
    tick();
  endtask

  task automatic test_lsu_write();
    lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
    sample();
    n_cmp++;
    if (lsu_gnt !== 1'b1 || ifu_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL lsu_wr_gnt: lsu %b ifu %b want 1 0", lsu_gnt, ifu_gnt);
    end
    tick();
    lsu_req = 0; lsu_we = 0; lsu_addr = 64'h5555; lsu_wdata = 64'h7777; lsu_wmask = 8'hF0;
    mem_gnt = 1;
    sample();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 64'h8000_1000 || mem_wdata !== 64'hDEAD_BEEF || mem_wmask !== 8'h0F) begin
      n_fail++;
      $display("FAIL lsu_wr_mem: we %b addr %h wdata %h mask %h want 1 80001000 deadbeef 0f", mem_we, mem_addr, mem_wdata, mem_wmask);
    end
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h0;
    sample();
    n_cmp++;
    if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsu_wr_resp: lsu %b ifu %b want 1 0", lsu_rvalid, ifu_rvalid);
    end
    tick();
    mem_rvalid = 0;
    sample();
    n_cmp++;
    if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL lsu_wr_once: lsu %b ifu %b state %0d want 0 0 0", lsu_rvalid, ifu_rvalid, dbg_state);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_mem_stall();
    ifu_req = 1; ifu_addr = 64'h8000_0100;
    sample();
    n_cmp++;
    if (ifu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_gnt: got %b want 1", ifu_gnt);
    end
    tick();
    for (int c = 0; c < 5; c++) begin
      ifu_addr = 64'h9000_0000 + 64'(c * 4);
      mem_gnt = 0;
      sample();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h8000_0100 || ifu_gnt !== 1'b0 || lsu_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: req %b addr %h gnts %b%b want 1 80000100 00", c, mem_req, mem_addr, ifu_gnt, lsu_gnt);
      end
      tick();
    end
    ifu_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h55;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 64'h55) begin
      n_fail++;
      $display("FAIL stall_resp: rvalid %b rdata %h want 1 55", ifu_rvalid, ifu_rdata);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_rvalid_in_req();
    do_reset();
    ifu_req = 1; ifu_addr = 64'h300;
    tick();
    ifu_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 64'h99;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL req_rvalid: ifu %b lsu %b want 0 0", ifu_rvalid, lsu_rvalid);
    end
    tick();
    mem_gnt = 0; mem_rvalid = 0;
    sample();
    n_cmp++;
    if (proto_err !== 1'b1 || dbg_state !== S_WAIT) begin
      n_fail++;
      $display("FAIL req_proto: perr %b state %0d want 1 2", proto_err, dbg_state);
    end
    mem_rvalid = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    ifu_req = 1; ifu_addr = 64'h400;
    tick();
    ifu_req = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    sample();
    n_cmp++;
    if (dbg_state !== S_WAIT || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_pre: state %0d perr %b want 2 0", dbg_state, proto_err);
    end
    tick();
    rst = 1; ifu_req = 1; mem_rdata = 64'hABCD;
    sample();
    n_cmp++;
    if (mem_req !== 1'b0 || ifu_gnt !== 1'b0 || ifu_rvalid !== 1'b0 || dbg_state !== S_IDLE || ifu_rdata !== 64'hABCD) begin
      n_fail++;
      $display("FAIL rstw_during: req %b gnt %b rvalid %b state %0d rdata %h want 0 0 0 0 abcd", mem_req, ifu_gnt, ifu_rvalid, dbg_state, ifu_rdata);
    end
    tick();
    rst = 0; ifu_req = 0; mem_rvalid = 1;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b0 || lsu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_late: ifu %b lsu %b want 0 0", ifu_rvalid, lsu_rvalid);
    end
    tick();
    mem_rvalid = 0;
    sample();
    n_cmp++;
    if (proto_err !== 1'b1 || dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL rstw_proto: perr %b state %0d want 1 0", proto_err, dbg_state);
    end
    tick();
  endtask

  task automatic test_req_withdrawn();
    do_reset();
    ifu_req = 1; ifu_addr = 64'h8000_2000;
    lsu_req = 1; lsu_addr = 64'h8000_3000;
    sample();
    n_cmp++;
    if (ifu_gnt !== 1'b1 || lsu_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_gnt: ifu %b lsu %b want 1 0", ifu_gnt, lsu_gnt);
    end
    tick();
    ifu_req = 0; lsu_req = 0; mem_gnt = 1;
    sample();
    n_cmp++;
    if (mem_addr !== 64'h8000_2000) begin
      n_fail++;
      $display("FAIL wd_addr: got %h want 80002000", mem_addr);
    end
    tick();
    mem_gnt = 0; mem_rvalid = 1;
    sample();
    n_cmp++;
    if (ifu_rvalid !== 1'b1 || lsu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_resp: ifu %b lsu %b want 1 0", ifu_rvalid, lsu_rvalid);
    end
    tick();
    mem_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_cmp++;
      if (lsu_gnt !== 1'b0 || mem_req !== 1'b0 || dbg_state !== S_IDLE) begin
        n_fail++;
        $display("FAIL wd_idle_%0d: lsu_gnt %b mem_req %b state %0d want 0 0 0", c, lsu_gnt, mem_req, dbg_state);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_lsu_write();
    test_mem_stall();
    test_rvalid_in_req();
    test_reset_mid_wait();
    test_req_withdrawn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
